// File: rtl/serial_addsub4.sv
// serial_addsub4: bit-serial two's-complement adder/subtractor.
// One full-adder bit per clock, LSB first, with a single carry flip-flop.
// Subtract is a + ~b + 1: b is inverted at load and the carry starts at 1.
module serial_addsub4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_next;

  // Full adder on the current LSBs of both operand registers.
  assign sum_bit    = opa[0] ^ opb[0] ^ carry;
  assign carry_next = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{mode}};
            carry <= mode;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= {sum_bit, acc[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(LAST)) begin
            // carry still holds the carry into the MSB at this point
            result <= {sum_bit, acc[WIDTH-1:1]};
            cout   <= carry_next;
            ovf    <= carry ^ carry_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub4.sv
// Directed self-checking bench for serial_addsub4 (WIDTH = 4).
module tb_serial_addsub4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] result;
  logic       cout;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  serial_addsub4 #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: start at edge N, expect done visible right after N+4.
  task automatic do_op(input string tag, input logic m, input logic [3:0] av,
                       input logic [3:0] bv, input logic [3:0] er,
                       input logic ec, input logic eo);
    int cycles;
    mode  = m;
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 8'(busy), 8'd1);
    cycles = 0;
    while (!done && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_lat"}, 8'(cycles), 8'd4);
    check({tag, "_res"}, 8'(result), 8'(er));
    check({tag, "_cout"}, 8'(cout), 8'(ec));
    check({tag, "_ovf"}, 8'(ovf), 8'(eo));
    step();
    check({tag, "_done1"}, 8'(done), 8'd0);
  endtask

  initial begin
    int ndone;
    int t;
    int pulses[3];
    int np;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    a      = 4'h0;
    b      = 4'h0;
    step();
    step();
    check("rst_res", 8'(result), 8'd0);
    check("rst_cout", 8'(cout), 8'd0);
    check("rst_ovf", 8'(ovf), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);

    // Start accepted at the first edge after reset deasserts.
    rst = 1'b0;
    do_op("add5_0", 1'b0, 4'b0101, 4'b0000, 4'b0101, 1'b0, 1'b0);
    do_op("add7_1", 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    do_op("addf_1", 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
    do_op("sub3_5", 1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0);
    do_op("sub8_1", 1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1);

    // Restart attempt and operand changes during RUN must be ignored.
    mode  = 1'b0;
    a     = 4'b0010;
    b     = 4'b0011;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    a     = 4'b1111;
    b     = 4'b1111;
    mode  = 1'b1;
    check("rs_hold_res", 8'(result), 8'h07);
    check("rs_hold_cout", 8'(cout), 8'd1);
    step();
    start = 1'b0;
    check("rs_busy", 8'(busy), 8'd1);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      step();
    end
    check("rs_ndone", 8'(ndone), 8'd1);
    check("rs_res", 8'(result), 8'b0101);
    check("rs_cout", 8'(cout), 8'd0);
    check("rs_ovf", 8'(ovf), 8'd0);

    // Reset at edge N+2 of an add aborts and clears everything.
    mode  = 1'b0;
    a     = 4'b0110;
    b     = 4'b0001;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("ab_res", 8'(result), 8'd0);
    check("ab_cout", 8'(cout), 8'd0);
    check("ab_ovf", 8'(ovf), 8'd0);
    check("ab_busy", 8'(busy), 8'd0);
    check("ab_done", 8'(done), 8'd0);
    rst = 1'b0;
    do_op("ab_fresh", 1'b0, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0);

    // start held high: done pulses WIDTH+2 = 6 cycles apart.
    mode  = 1'b0;
    a     = 4'b0001;
    b     = 4'b0001;
    start = 1'b1;
    np    = 0;
    t     = 0;
    while (np < 3 && t < 40) begin
      step();
      t++;
      if (done) begin
        pulses[np] = t;
        np++;
      end
    end
    start = 1'b0;
    check("b2b_npulse", 8'(np), 8'd3);
    if (np == 3) begin
      check("b2b_gap1", 8'(pulses[1] - pulses[0]), 8'd6);
      check("b2b_gap2", 8'(pulses[2] - pulses[1]), 8'd6);
    end
    check("b2b_res", 8'(result), 8'b0010);
    check("b2b_cout", 8'(cout), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
